// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: single-entry valid/ready stage with operand select.
// Define ID_EX_FWD_EN to add EX/MEM + MEM/WB forwarding and hold-refresh.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_alu_src,
  input  logic [3:0]      in_alu_control,
  input  logic            in_reg_write,
  input  logic            flush,
  input  logic            exm_reg_write,
  input  logic            wb_reg_write,
  input  logic [4:0]      exm_rd,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic [XLEN-1:0] wb_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_alu_control,
  output logic [4:0]      out_rd,
  output logic            out_reg_write
);

  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic            alu_src_q;
  logic            capture;
  logic [XLEN-1:0] a_src;
  logic [XLEN-1:0] rs2_src;
  logic            refresh_a;
  logic            refresh_b;

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

`ifdef ID_EX_FWD_EN
  // EX/MEM is the younger producer, so it wins over MEM/WB.
  function automatic logic [XLEN-1:0] fwd(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf
  );
    if (exm_reg_write && exm_rd == rs && rs != 5'd0)
      return exm_result;
    else if (wb_reg_write && wb_rd == rs && rs != 5'd0)
      return wb_result;
    else
      return rf;
  endfunction

  assign a_src   = fwd(in_rs1, in_rs1_data);
  assign rs2_src = fwd(in_rs2, in_rs2_data);

  assign refresh_a = wb_reg_write && wb_rd == rs1_q
                     && rs1_q != 5'd0;
  assign refresh_b = wb_reg_write && wb_rd == rs2_q
                     && rs2_q != 5'd0 && !alu_src_q;
`else
  logic unused_fwd;

  assign a_src     = in_rs1_data;
  assign rs2_src   = in_rs2_data;
  assign refresh_a = 1'b0;
  assign refresh_b = 1'b0;
  assign unused_fwd = ^{exm_reg_write, wb_reg_write,
                        exm_rd, wb_rd, exm_result,
                        rs1_q, rs2_q, alu_src_q};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_a           <= '0;
      out_b           <= '0;
      out_alu_control <= 4'b0000;
      out_rd          <= 5'd0;
      out_reg_write   <= 1'b0;
      rs1_q           <= 5'd0;
      rs2_q           <= 5'd0;
      alu_src_q       <= 1'b0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
    end else if (capture) begin
      out_valid       <= 1'b1;
      out_a           <= a_src;
      out_b           <= in_alu_src ? in_imm : rs2_src;
      out_alu_control <= in_alu_control;
      out_rd          <= in_rd;
      out_reg_write   <= in_reg_write;
      rs1_q           <= in_rs1;
      rs2_q           <= in_rs2;
      alu_src_q       <= in_alu_src;
    end else if (in_ready) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
    end else begin
      // Held under backpressure: keep operands current with writeback.
      if (refresh_a) out_a <= wb_result;
      if (refresh_b) out_b <= wb_result;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage.
// Expectations follow the build: ID_EX_FWD_EN defined or not.
module tb_id_ex_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rs1, in_rs2, in_rd;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm;
  logic            in_alu_src;
  logic [3:0]      in_alu_control;
  logic            in_reg_write;
  logic            flush;
  logic            exm_reg_write, wb_reg_write;
  logic [4:0]      exm_rd, wb_rd;
  logic [XLEN-1:0] exm_result, wb_result;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a, out_b;
  logic [3:0]      out_alu_control;
  logic [4:0]      out_rd;
  logic            out_reg_write;

  int passed = 0;
  int total  = 0;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_alu_src(in_alu_src),
    .in_alu_control(in_alu_control),
    .in_reg_write(in_reg_write), .flush(flush),
    .exm_reg_write(exm_reg_write), .wb_reg_write(wb_reg_write),
    .exm_rd(exm_rd), .wb_rd(wb_rd),
    .exm_result(exm_result), .wb_result(wb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .out_alu_control(out_alu_control), .out_rd(out_rd),
    .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1,
                       input logic [31:0] d1,
                       input logic [4:0] rs2,
                       input logic [31:0] d2,
                       input logic src,
                       input logic [31:0] imm,
                       input logic [3:0] ctl,
                       input logic [4:0] rd);
    in_valid       = 1'b1;
    in_rs1         = rs1;
    in_rs1_data    = d1;
    in_rs2         = rs2;
    in_rs2_data    = d2;
    in_alu_src     = src;
    in_imm         = imm;
    in_alu_control = ctl;
    in_rd          = rd;
    in_reg_write   = 1'b1;
  endtask

  task automatic no_fwd();
    exm_reg_write = 1'b0;
    wb_reg_write  = 1'b0;
    exm_rd        = 5'd0;
    wb_rd         = 5'd0;
    exm_result    = '0;
    wb_result     = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_a"}, out_a, 32'd0);
    check({tag, "_b"}, out_b, 32'd0);
    check({tag, "_ctl"}, 32'(out_alu_control), 32'd0);
    check({tag, "_rd"}, 32'(out_rd), 32'd0);
    check({tag, "_rw"}, 32'(out_reg_write), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_alu_src = 0; in_alu_control = 0; in_reg_write = 0;
    no_fwd();
    tick();
    check_zero("reset");
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Forward priority: both producers target rs1=5.
    drive(5'd5, 32'h100, 5'd6, 32'h200, 1'b0, 32'h0,
          4'b0010, 5'd3);
    exm_reg_write = 1'b1; exm_rd = 5'd5; exm_result = 32'h11;
    wb_reg_write  = 1'b1; wb_rd  = 5'd5; wb_result  = 32'h22;
    tick();
    check("cap_valid", 32'(out_valid), 32'd1);
`ifdef ID_EX_FWD_EN
    check("fwd_prio_a", out_a, 32'h11);
`else
    check("nofwd_a", out_a, 32'h100);
`endif
    check("cap_b", out_b, 32'h200);
    check("cap_ctl", 32'(out_alu_control), 32'h2);
    check("cap_rd", 32'(out_rd), 32'd3);
    check("cap_rw", 32'(out_reg_write), 32'd1);

    // x0 never forwards.
    drive(5'd0, 32'h0, 5'd6, 32'h33, 1'b0, 32'h0,
          4'b1101, 5'd4);
    no_fwd();
    exm_reg_write = 1'b1; exm_rd = 5'd0;
    exm_result = 32'hFFFF_FFFF;
    tick();
    check("x0_a", out_a, 32'h0);
    check("x0_ctl", 32'(out_alu_control), 32'hD);

    // Immediate path ignores forwarding.
    drive(5'd1, 32'h7, 5'd9, 32'h44, 1'b1, 32'hFFFF_FFF0,
          4'b0000, 5'd2);
    no_fwd();
    exm_reg_write = 1'b1; exm_rd = 5'd9; exm_result = 32'h99;
    tick();
    check("imm_b", out_b, 32'hFFFF_FFF0);
    check("imm_a", out_a, 32'h7);

    // Backpressure with writeback refresh of rs2.
    drive(5'd8, 32'h55, 5'd7, 32'h1234, 1'b0, 32'h0,
          4'b0110, 5'd10);
    no_fwd();
    tick();
    check("bp_cap_b", out_b, 32'h1234);
    out_ready = 1'b0;
    drive(5'd11, 32'hAAAA, 5'd12, 32'hBBBB, 1'b0, 32'h0,
          4'b0001, 5'd13);
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_result = 32'hABCD;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("bp_in_ready2", 32'(in_ready), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
`ifdef ID_EX_FWD_EN
    check("bp_refresh_b", out_b, 32'hABCD);
`else
    check("bp_hold_b", out_b, 32'h1234);
`endif
    check("bp_a", out_a, 32'h55);
    check("bp_ctl", 32'(out_alu_control), 32'h6);
    check("bp_rd", 32'(out_rd), 32'd10);

    // Flush dominates capture.
    no_fwd();
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_rw", 32'(out_reg_write), 32'd0);
    flush = 1'b0;

    // Capture then drain with no new input.
    tick();
    check("recap_rd", 32'(out_rd), 32'd13);
    in_valid = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_rw", 32'(out_reg_write), 32'd0);

    // Asynchronous reset while holding.
    drive(5'd3, 32'h77, 5'd4, 32'h88, 1'b0, 32'h0,
          4'b0011, 5'd6);
    tick();
    out_ready = 1'b0;
    tick();
    check("hold_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    tick();
    check("rst_no_cap", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_rst_cap", 32'(out_valid), 32'd1);
    check("post_rst_b", out_b, 32'h88);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
